pwm_decoder: RTL and testbench

- Receive end of the PWM link: measures an incoming PWM waveform and recovers the 2-bit duty code that produced it.
- Matching source: period of 8 clocks, high for the first 2*duty clocks of each period (duty 0..3 gives high times 0, 2, 4, 6), never continuously high.
- Used for loopback self-test of the PWM generator and for decoding PWM from external sources.

---
 rtl/pwm_decoder.sv | 161 ++++++++++++++++
 tb/tb_pwm_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM receive decoder: synchronizes pwm_in, measures the period and high time
// between rising edges, and recovers the 2-bit duty code of the source.
module pwm_decoder #(
  parameter int PERIOD      = 8,
  parameter int CNT_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [1:0] duty_cycle,
  output logic       duty_valid,
  output logic       error,
  output logic       locked
);
  localparam int TIMEOUT = 2 * PERIOD;
  localparam logic [CNT_W-1:0] PERIOD_C   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(6);
  localparam logic [CNT_W-1:0] ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    ZERO    = 2'd2
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   timeout;
  logic                   accept;
  logic                   zero_high;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;
  logic [1:0]             duty_next;
  logic                   valid_next;
  logic                   error_next;
  logic                   locked_next;

  assign pwm_s     = sync[SYNC_STAGES-1];
  assign rise      = pwm_s & ~pwm_d;
  // A rise in the same cycle always wins over the timeout.
  assign timeout   = ~rise & (period_cnt == TIMEOUT_C);
  assign zero_high = (high_cnt == ZERO_C);
  assign accept    = (period_cnt == PERIOD_C) & ~high_cnt[0] & (high_cnt <= MAX_HIGH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= {SYNC_STAGES{1'b0}};
      pwm_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pwm_in};
      pwm_d <= pwm_s;
    end
  end

  // Counters restart at 1 on a rise so they hold the full interval at the next rise.
  always_ff @(posedge clk) begin
    if (reset || timeout) begin
      period_cnt <= ZERO_C;
      high_cnt   <= ZERO_C;
    end else if (rise) begin
      period_cnt <= ONE_C;
      high_cnt   <= ONE_C;
    end else begin
      period_cnt <= period_cnt + ONE_C;
      high_cnt   <= high_cnt + CNT_W'(pwm_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SEARCH: begin
        if (rise)                        next_state = MEASURE;
        else if (timeout && zero_high)   next_state = ZERO;
        else                             next_state = SEARCH;
      end
      MEASURE: begin
        if (rise)                        next_state = MEASURE;
        else if (timeout && zero_high)   next_state = ZERO;
        else if (timeout)                next_state = SEARCH;
        else                             next_state = MEASURE;
      end
      ZERO: begin
        if (rise) next_state = MEASURE;
        else      next_state = ZERO;
      end
      default: next_state = SEARCH;
    endcase
  end

  always_comb begin
    duty_next   = duty_cycle;
    valid_next  = 1'b0;
    error_next  = 1'b0;
    locked_next = locked;
    case (state)
      SEARCH, MEASURE: begin
        if (rise && (state == MEASURE)) begin
          if (accept) begin
            duty_next   = high_cnt[2:1];
            valid_next  = 1'b1;
            locked_next = 1'b1;
          end else begin
            error_next  = 1'b1;
            locked_next = 1'b0;
          end
        end else if (timeout && zero_high) begin
          duty_next   = 2'd0;
          valid_next  = 1'b1;
          locked_next = 1'b1;
        end else if (timeout) begin
          error_next  = 1'b1;
          locked_next = 1'b0;
        end else begin
          duty_next   = duty_cycle;
        end
      end
      ZERO: begin
        if (rise) begin
          locked_next = 1'b0;
        end else if (timeout) begin
          duty_next   = 2'd0;
          valid_next  = 1'b1;
          locked_next = 1'b1;
        end else begin
          duty_next   = duty_cycle;
        end
      end
      default: begin
        duty_next   = 2'd0;
        locked_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_cycle <= 2'd0;
      duty_valid <= 1'b0;
      error      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      duty_cycle <= duty_next;
      duty_valid <= valid_next;
      error      <= error_next;
      locked     <= locked_next;
    end
  end
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: drives hand-built PWM waveforms and checks
// decoded duty, pulses and lock state against hand-computed values.
module tb_pwm_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [1:0] duty_cycle;
  logic       duty_valid;
  logic       error;
  logic       locked;

  int n_assert = 0;
  int n_fail   = 0;
  int nv = 0;
  int ne = 0;
  int both = 0;

  pwm_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_cycle (duty_cycle),
    .duty_valid (duty_valid),
    .error      (error),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive pwm_in, observe outputs of the edge that sampled it.
  task automatic cyc(input logic v);
    pwm_in = v;
    @(negedge clk);
    nv = nv + int'(duty_valid);
    ne = ne + int'(error);
    if (duty_valid && error) both++;
  endtask

  task automatic pwm(input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc(1'b1);
    for (int i = 0; i < lo; i++) cyc(1'b0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;

    // Reset state, then duty-2 stream.
    do_reset();
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_locked", int'(locked), 0);
    pwm(4, 4);
    cyc(1'b1); cyc(1'b1);
    chk("d2_early", int'(duty_valid), 0);
    cyc(1'b1);
    chk("d2_first_valid", int'(duty_valid), 1);
    chk("d2_first_duty", int'(duty_cycle), 2);
    chk("d2_first_locked", int'(locked), 1);
    cyc(1'b1); pwm(0, 4);
    nv = 0; ne = 0;
    repeat (3) pwm(4, 4);
    chk("d2_valid_count", nv, 3);
    chk("d2_error_count", ne, 0);
    chk("d2_duty", int'(duty_cycle), 2);
    chk("d2_locked", int'(locked), 1);

    // Held low: duty 0 via timeout, then a duty-3 stream.
    do_reset();
    nv = 0; ne = 0;
    pwm(0, 15);
    chk("zero_none_early", nv, 0);
    pwm(0, 25);
    chk("zero_valid_count", nv, 2);
    chk("zero_duty", int'(duty_cycle), 0);
    chk("zero_locked", int'(locked), 1);
    chk("zero_errors", ne, 0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("zero_rise_unlock", int'(locked), 0);
    pwm(3, 2);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("d3_valid", int'(duty_valid), 1);
    chk("d3_duty", int'(duty_cycle), 3);
    chk("d3_locked", int'(locked), 1);
    pwm(3, 2);

    // Loopback-style sweep 0 -> 1 -> 2 -> 3, four periods each.
    do_reset();
    ne = 0;
    pwm(0, 32);
    chk("sweep0_duty", int'(duty_cycle), 0);
    for (int d = 1; d < 4; d++) begin
      repeat (2) pwm(2 * d, 8 - 2 * d);
      chk("sweep_track", int'(duty_cycle), d);
      repeat (2) pwm(2 * d, 8 - 2 * d);
      chk("sweep_locked", int'(locked), 1);
    end
    chk("sweep_errors", ne, 0);

    // Malformed periods: odd high time, then period 9, then recovery.
    pwm(3, 5);
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    chk("odd_error", int'(error), 1);
    chk("odd_valid", int'(duty_valid), 0);
    chk("odd_locked", int'(locked), 0);
    chk("odd_duty_kept", int'(duty_cycle), 3);
    cyc(1'b0);
    chk("odd_error_pulse", int'(error), 0);
    pwm(0, 5);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("p9_error", int'(error), 1);
    chk("p9_locked", int'(locked), 0);
    chk("p9_duty_kept", int'(duty_cycle), 3);
    cyc(1'b1); pwm(0, 4);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("recover_valid", int'(duty_valid), 1);
    chk("recover_duty", int'(duty_cycle), 2);
    chk("recover_locked", int'(locked), 1);
    cyc(1'b1); pwm(0, 4);

    // Stuck high after lock.
    ne = 0;
    pwm(18, 0);
    chk("stuck_no_early_error", ne, 0);
    cyc(1'b1);
    chk("stuck_error", int'(error), 1);
    chk("stuck_locked", int'(locked), 0);
    cyc(1'b1);

    // Reset mid-period during a duty-1 stream.
    pwm(0, 4);
    repeat (3) pwm(2, 6);
    chk("d1_duty", int'(duty_cycle), 1);
    chk("d1_locked", int'(locked), 1);
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    reset  = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_duty", int'(duty_cycle), 0);
    chk("mid_rst_valid", int'(duty_valid), 0);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_locked", int'(locked), 0);
    reset = 1'b0;
    nv = 0;
    pwm(0, 2);
    pwm(2, 6);
    cyc(1'b1); cyc(1'b1);
    chk("post_rst_no_report", nv, 0);
    cyc(1'b0);
    chk("post_rst_valid", int'(duty_valid), 1);
    chk("post_rst_duty", int'(duty_cycle), 1);
    chk("post_rst_locked", int'(locked), 1);
    pwm(0, 5);

    chk("valid_error_exclusive", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
